// File: rtl/drive_pkg.sv
// Shared types and constants for the line-following drive sequencer.
package drive_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    TRACK      = 3'd1,
    BRAKE      = 3'd2,
    BACKUP     = 3'd3,
    WAIT_CLEAR = 3'd4,
    SEARCH     = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    MODE_STOP        = 3'd0,
    MODE_FWD         = 3'd1,
    MODE_LEFT        = 3'd2,
    MODE_RIGHT       = 3'd3,
    MODE_SHARP_LEFT  = 3'd4,
    MODE_SHARP_RIGHT = 3'd5,
    MODE_BACK        = 3'd6
  } mode_t;

  // SIDE_NONE marks a line pattern that is not a turn and must not touch last_dir
  typedef enum logic [1:0] {
    SIDE_NONE  = 2'd0,
    SIDE_LEFT  = 2'd1,
    SIDE_RIGHT = 2'd2
  } side_t;

  localparam logic [1:0] DIR_COAST = 2'b00;
  localparam logic [1:0] DIR_FWD   = 2'b01;
  localparam logic [1:0] DIR_REV   = 2'b10;
  localparam logic [1:0] DIR_BRAKE = 2'b11;

endpackage

// File: rtl/drive_sequencer_line_decode.sv
// Combinational map from tracker bits {left,mid,right} to a TRACK mode and turn side.
module line_decode
  import drive_pkg::*;
(
  input  logic [2:0] line,
  input  mode_t      prev_mode,
  output mode_t      mode,
  output side_t      turn_side
);

  // 101 and 000 carry no usable steering information, so the previous mode is held
  always_comb begin
    mode      = prev_mode;
    turn_side = SIDE_NONE;
    case (line)
      3'b010, 3'b111: mode = MODE_FWD;
      3'b110: begin
        mode      = MODE_LEFT;
        turn_side = SIDE_LEFT;
      end
      3'b100: begin
        mode      = MODE_SHARP_LEFT;
        turn_side = SIDE_LEFT;
      end
      3'b011: begin
        mode      = MODE_RIGHT;
        turn_side = SIDE_RIGHT;
      end
      3'b001: begin
        mode      = MODE_SHARP_RIGHT;
        turn_side = SIDE_RIGHT;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/drive_sequencer.sv
// Drive sequencer FSM: line tracking, brake/backup/clear obstacle recovery.
// Define DRIVE_SEQUENCER_SEARCH_EN to enable lost-line SEARCH with timeout fault.
module drive_sequencer
  import drive_pkg::*;
#(
  parameter int BRAKE_CYC  = 1000,
  parameter int BACK_CYC   = 50000,
  parameter int CLEAR_CYC  = 2000,
  parameter int SEARCH_CYC = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] line,
  input  logic       stop,
  output logic [2:0] mode,
  output logic [1:0] left,
  output logic [1:0] right,
  output logic [2:0] state,
  output logic       fault
);

  localparam int MAX_AB  = (BRAKE_CYC > BACK_CYC) ? BRAKE_CYC : BACK_CYC;
  localparam int MAX_CS  = (CLEAR_CYC > SEARCH_CYC) ? CLEAR_CYC : SEARCH_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CS) ? MAX_AB : MAX_CS;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef logic [CNT_W-1:0] cnt_t;

  // Loads are CYC-1 because the exit fires on the cycle the counter reads zero
  localparam cnt_t BRAKE_LOAD  = cnt_t'(BRAKE_CYC - 1);
  localparam cnt_t BACK_LOAD   = cnt_t'(BACK_CYC - 1);
  localparam cnt_t CLEAR_LOAD  = cnt_t'(CLEAR_CYC - 1);
`ifdef DRIVE_SEQUENCER_SEARCH_EN
  localparam cnt_t SEARCH_LOAD = cnt_t'(SEARCH_CYC - 1);
`endif

  state_t state_q;
  mode_t  mode_q;
  side_t  last_dir;
  cnt_t   cnt;
  logic [1:0] left_q;
  logic [1:0] right_q;
  logic       fault_q;

  mode_t dec_mode;
  side_t dec_side;

  line_decode u_line_decode (
    .line      (line),
    .prev_mode (mode_q),
    .mode      (dec_mode),
    .turn_side (dec_side)
  );

  // Outputs are computed from the current state, so they trail the state by one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt      <= '0;
      last_dir <= SIDE_LEFT;
      fault_q  <= 1'b0;
      mode_q   <= MODE_STOP;
      left_q   <= DIR_BRAKE;
      right_q  <= DIR_BRAKE;
    end else begin
      case (state_q)
        IDLE: begin
          mode_q  <= MODE_STOP;
          left_q  <= DIR_BRAKE;
          right_q <= DIR_BRAKE;
          if (start) begin
            state_q <= TRACK;
            cnt     <= '0;
            fault_q <= 1'b0;
          end
        end

        TRACK: begin
          mode_q  <= dec_mode;
          left_q  <= DIR_FWD;
          right_q <= DIR_FWD;
          if (dec_side != SIDE_NONE) last_dir <= dec_side;
          if (stop) begin
            state_q <= BRAKE;
            cnt     <= BRAKE_LOAD;
          end
`ifdef DRIVE_SEQUENCER_SEARCH_EN
          else if (line == 3'b000) begin
            state_q <= SEARCH;
            cnt     <= SEARCH_LOAD;
          end
`endif
        end

        BRAKE: begin
          mode_q  <= MODE_STOP;
          left_q  <= DIR_BRAKE;
          right_q <= DIR_BRAKE;
          if (cnt == '0) begin
            state_q <= BACKUP;
            cnt     <= BACK_LOAD;
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end

        BACKUP: begin
          mode_q  <= MODE_BACK;
          left_q  <= DIR_REV;
          right_q <= DIR_REV;
          if (cnt == '0) begin
            state_q <= WAIT_CLEAR;
            cnt     <= CLEAR_LOAD;
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end

        WAIT_CLEAR: begin
          mode_q  <= MODE_STOP;
          left_q  <= DIR_BRAKE;
          right_q <= DIR_BRAKE;
          if (stop) begin
            cnt <= CLEAR_LOAD;
          end else if (cnt == '0) begin
            state_q <= TRACK;
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end

        // Entry into SEARCH is the only thing the build macro gates
        SEARCH: begin
          if (last_dir == SIDE_RIGHT) begin
            mode_q  <= MODE_SHARP_RIGHT;
            left_q  <= DIR_FWD;
            right_q <= DIR_REV;
          end else begin
            mode_q  <= MODE_SHARP_LEFT;
            left_q  <= DIR_REV;
            right_q <= DIR_FWD;
          end
          if (stop) begin
            state_q <= BRAKE;
            cnt     <= BRAKE_LOAD;
          end else if (line != 3'b000) begin
            state_q <= TRACK;
            cnt     <= '0;
          end else if (cnt == '0) begin
            state_q <= IDLE;
            fault_q <= 1'b1;
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          cnt     <= '0;
          mode_q  <= MODE_STOP;
          left_q  <= DIR_BRAKE;
          right_q <= DIR_BRAKE;
        end
      endcase
    end
  end

  assign mode  = mode_q;
  assign left  = left_q;
  assign right = right_q;
  assign state = state_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// Self-checking bench for drive_sequencer; vectors queue their expectations and are popped after each edge.
module tb_drive_sequencer;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_TRACK = 3'd1;
  localparam logic [2:0] S_BRAKE = 3'd2;
  localparam logic [2:0] S_BACK  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_SRCH  = 3'd5;

  typedef struct packed {
    logic       start;
    logic [2:0] line;
    logic       stop;
    logic       rst_n;
    logic [2:0] exp_state;
    logic [2:0] exp_mode;
    logic [1:0] exp_left;
    logic [1:0] exp_right;
    logic       exp_fault;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] line;
  logic       stop;
  logic [2:0] mode;
  logic [1:0] left;
  logic [1:0] right;
  logic [2:0] state;
  logic       fault;

  int    tests = 0;
  int    failed = 0;
  int    step_no = 0;
  string phase = "init";
  vec_t  expq[$];
  vec_t  main_tbl[12];

  drive_sequencer #(
    .BRAKE_CYC  (4),
    .BACK_CYC   (8),
    .CLEAR_CYC  (3),
    .SEARCH_CYC (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .line  (line),
    .stop  (stop),
    .mode  (mode),
    .left  (left),
    .right (right),
    .state (state),
    .fault (fault)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkv(logic st, logic [2:0] ln, logic sp, logic rn,
                               logic [2:0] es, logic [2:0] em, logic [1:0] el,
                               logic [1:0] er, logic ef);
    vec_t r;
    r.start = st; r.line = ln; r.stop = sp; r.rst_n = rn;
    r.exp_state = es; r.exp_mode = em; r.exp_left = el; r.exp_right = er; r.exp_fault = ef;
    return r;
  endfunction

  task automatic cmp(input string what, input logic [2:0] got, input logic [2:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("[TB] FAIL %s/%s step %0d: got %0d want %0d", phase, what, step_no, got, want);
    end
  endtask

  task automatic applyStimulus(input vec_t vin);
    start = vin.start;
    line  = vin.line;
    stop  = vin.stop;
    rst_n = vin.rst_n;
    expq.push_back(vin);
  endtask

  task automatic checkOutput();
    vec_t e;
    if (expq.size() == 0) begin
      tests++;
      failed++;
      $display("[TB] FAIL %s/scoreboard step %0d: got empty queue want entry", phase, step_no);
      return;
    end
    e = expq.pop_front();
    cmp("state", state, e.exp_state);
    cmp("mode", mode, e.exp_mode);
    cmp("left", {1'b0, left}, {1'b0, e.exp_left});
    cmp("right", {1'b0, right}, {1'b0, e.exp_right});
    cmp("fault", {2'b00, fault}, {2'b00, e.exp_fault});
  endtask

  task automatic run(input vec_t vin);
    applyStimulus(vin);
    @(posedge clk);
    #1;
    checkOutput();
    step_no++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    start = 1'b0; line = 3'b010; stop = 1'b0; rst_n = 1'b0;

    main_tbl[0]  = mkv(1, 3'b010, 0, 1, S_TRACK, 3'd0, 2'b11, 2'b11, 0);
    main_tbl[1]  = mkv(0, 3'b010, 0, 1, S_TRACK, 3'd1, 2'b01, 2'b01, 0);
    main_tbl[2]  = mkv(0, 3'b110, 0, 1, S_TRACK, 3'd2, 2'b01, 2'b01, 0);
    main_tbl[3]  = mkv(0, 3'b100, 0, 1, S_TRACK, 3'd4, 2'b01, 2'b01, 0);
    main_tbl[4]  = mkv(0, 3'b101, 0, 1, S_TRACK, 3'd4, 2'b01, 2'b01, 0);
    main_tbl[5]  = mkv(0, 3'b011, 0, 1, S_TRACK, 3'd3, 2'b01, 2'b01, 0);
    main_tbl[6]  = mkv(0, 3'b001, 0, 1, S_TRACK, 3'd5, 2'b01, 2'b01, 0);
    main_tbl[7]  = mkv(0, 3'b111, 0, 1, S_TRACK, 3'd1, 2'b01, 2'b01, 0);
    main_tbl[8]  = mkv(0, 3'b101, 0, 1, S_TRACK, 3'd1, 2'b01, 2'b01, 0);
    main_tbl[9]  = mkv(0, 3'b011, 0, 1, S_TRACK, 3'd3, 2'b01, 2'b01, 0);
    main_tbl[10] = mkv(1, 3'b010, 0, 1, S_TRACK, 3'd1, 2'b01, 2'b01, 0);
    main_tbl[11] = mkv(0, 3'b010, 0, 1, S_TRACK, 3'd1, 2'b01, 2'b01, 0);

    phase = "reset";
    run(mkv(0, 3'b010, 0, 0, S_IDLE, 3'd0, 2'b11, 2'b11, 0));
    run(mkv(0, 3'b010, 0, 0, S_IDLE, 3'd0, 2'b11, 2'b11, 0));

    phase = "track";
    for (int i = 0; i < 12; i++) run(main_tbl[i]);

    phase = "brake";
    run(mkv(0, 3'b010, 1, 1, S_BRAKE, 3'd1, 2'b01, 2'b01, 0));
    for (int i = 0; i < 4; i++)
      run(mkv(0, 3'b010, 0, 1, (i == 3) ? S_BACK : S_BRAKE, 3'd0, 2'b11, 2'b11, 0));

    phase = "backup";
    for (int i = 0; i < 8; i++)
      run(mkv(0, 3'b010, (i == 2), 1, (i == 7) ? S_WAIT : S_BACK, 3'd6, 2'b10, 2'b10, 0));

    phase = "wait_clear";
    begin
      logic [6:0] stop_seq;
      stop_seq = 7'b1001000;
      for (int i = 0; i < 7; i++)
        run(mkv(0, 3'b010, stop_seq[6-i], 1, (i == 6) ? S_TRACK : S_WAIT, 3'd0, 2'b11, 2'b11, 0));
    end
    run(mkv(0, 3'b010, 0, 1, S_TRACK, 3'd1, 2'b01, 2'b01, 0));

`ifdef DRIVE_SEQUENCER_SEARCH_EN
    phase = "search_recover";
    run(mkv(0, 3'b000, 0, 1, S_SRCH, 3'd1, 2'b01, 2'b01, 0));
    for (int i = 0; i < 4; i++)
      run(mkv(0, 3'b000, 0, 1, S_SRCH, 3'd5, 2'b01, 2'b10, 0));
    run(mkv(0, 3'b001, 0, 1, S_TRACK, 3'd5, 2'b01, 2'b10, 0));
    run(mkv(0, 3'b001, 0, 1, S_TRACK, 3'd5, 2'b01, 2'b01, 0));

    phase = "search_timeout";
    run(mkv(0, 3'b000, 0, 1, S_SRCH, 3'd5, 2'b01, 2'b01, 0));
    for (int i = 0; i < 10; i++)
      run(mkv(0, 3'b000, 0, 1, (i == 9) ? S_IDLE : S_SRCH, 3'd5, 2'b01, 2'b10, (i == 9)));
    run(mkv(0, 3'b000, 0, 1, S_IDLE, 3'd0, 2'b11, 2'b11, 1));
    run(mkv(1, 3'b010, 0, 1, S_TRACK, 3'd0, 2'b11, 2'b11, 0));
    run(mkv(0, 3'b010, 0, 1, S_TRACK, 3'd1, 2'b01, 2'b01, 0));
`else
    phase = "lost_line_hold";
    for (int i = 0; i < 3; i++)
      run(mkv(0, 3'b000, 0, 1, S_TRACK, 3'd1, 2'b01, 2'b01, 0));
    run(mkv(0, 3'b110, 0, 1, S_TRACK, 3'd2, 2'b01, 2'b01, 0));
    run(mkv(0, 3'b000, 0, 1, S_TRACK, 3'd2, 2'b01, 2'b01, 0));
`endif

    phase = "start_and_stop";
    run(mkv(0, 3'b010, 0, 0, S_IDLE, 3'd0, 2'b11, 2'b11, 0));
    run(mkv(1, 3'b010, 1, 1, S_TRACK, 3'd0, 2'b11, 2'b11, 0));
    run(mkv(0, 3'b010, 1, 1, S_BRAKE, 3'd1, 2'b01, 2'b01, 0));
    for (int i = 0; i < 4; i++)
      run(mkv(0, 3'b010, 0, 1, (i == 3) ? S_BACK : S_BRAKE, 3'd0, 2'b11, 2'b11, 0));

    phase = "reset_in_backup";
    run(mkv(0, 3'b010, 0, 1, S_BACK, 3'd6, 2'b10, 2'b10, 0));
    run(mkv(0, 3'b010, 0, 1, S_BACK, 3'd6, 2'b10, 2'b10, 0));
    run(mkv(0, 3'b010, 0, 0, S_IDLE, 3'd0, 2'b11, 2'b11, 0));
    run(mkv(1, 3'b010, 0, 1, S_TRACK, 3'd0, 2'b11, 2'b11, 0));
    run(mkv(0, 3'b010, 0, 1, S_TRACK, 3'd1, 2'b01, 2'b01, 0));
`ifdef DRIVE_SEQUENCER_SEARCH_EN
    phase = "last_dir_after_reset";
    run(mkv(0, 3'b000, 0, 1, S_SRCH, 3'd1, 2'b01, 2'b01, 0));
    run(mkv(0, 3'b000, 0, 1, S_SRCH, 3'd4, 2'b10, 2'b01, 0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/drive_sequencer.md
DRIVE_SEQUENCER -- requirements
Module: drive_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
 - BRAKE_CYC, 1000, cycles held in BRAKE.
 - BACK_CYC, 50000, cycles held in BACKUP.
 - CLEAR_CYC, 2000, consecutive stop-low cycles required to leave WAIT_CLEAR.
 - SEARCH_CYC, 200000, SEARCH timeout in cycles.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
 - clk, in, 1, system clock; the only clock.
 - rst_n, in, 1, reset, synchronous, active-low.
 - start, in, 1, one-cycle pulse that starts the run.
 - line, in, 3, {left,mid,right} tracker bits; 1 = on line.
 - stop, in, 1, obstacle flag from the sonic block.
 - mode, out, 3, speed/turn code to the motor PWM block.
 - left, out, 2, left wheel direction.
 - right, out, 2, right wheel direction.
 - state, out, 3, current FSM state, for debug.
 - fault, out, 1, sticky; set when the line is lost past the timeout.

Function
REQ-003 Direction codes SHALL be: 01 forward, 10 reverse, 11 brake, 00 coast.
REQ-004 FSM states SHALL be IDLE, TRACK, BRAKE, BACKUP, WAIT_CLEAR, SEARCH.
REQ-005 All outputs SHALL be registered, changing one cycle after the state or inputs that cause them.
REQ-006 IDLE: left=right=11, mode=MODE_STOP; start moves to TRACK, which clears fault.
REQ-007 TRACK line map SHALL be:
 - 010 or 111 -> FWD.
 - 110 -> LEFT.
 - 100 -> SHARP_LEFT.
 - 011 -> RIGHT.
 - 001 -> SHARP_RIGHT.
 - 101 -> hold previous mode.
REQ-008 In TRACK, left=right=01.
REQ-009 last_dir SHALL record the side of the most recent LEFT/SHARP_LEFT or RIGHT/SHARP_RIGHT; its reset value is left.
REQ-010 stop high in TRACK or SEARCH SHALL enter BRAKE next cycle; stop has priority over every line pattern.
REQ-011 BRAKE: left=right=11, mode=MODE_STOP for exactly BRAKE_CYC cycles, then BACKUP.
REQ-012 BACKUP: left=right=10, mode=MODE_BACK for exactly BACK_CYC cycles, then WAIT_CLEAR; stop is ignored during BACKUP.
REQ-013 WAIT_CLEAR: left=right=11; counts consecutive stop-low cycles; stop high restarts the count from 0; reaching CLEAR_CYC enters TRACK.
REQ-014 A single down-counter, width $clog2 of the largest parameter, SHALL be loaded on each state entry; the transition fires when it reaches 0, with no wrap.
REQ-015 start outside IDLE SHALL be ignored.
REQ-016 Simultaneous start and stop in IDLE SHALL enter TRACK; BRAKE then follows on the next cycle if stop is still high.

Reset
REQ-017 rst_n low at a clock edge SHALL force, regardless of state (including mid-BACKUP):
 - state=IDLE, counter=0, last_dir=left, fault=0.
 - mode=MODE_STOP, left=right=11.
REQ-018 The first start accepted after reset SHALL be in the first cycle rst_n is high.

Configuration
REQ-019 The macro DRIVE_SEQUENCER_SEARCH_EN SHALL control lost-line handling as follows.
 - Defined, entry: line=000 in TRACK enters SEARCH.
 - Defined, SEARCH outputs: spin toward last_dir (left: left=10, right=01, mode=SHARP_LEFT; mirrored for right).
 - Defined, SEARCH exits: any nonzero line returns to TRACK; SEARCH_CYC elapsed enters IDLE with fault=1.
 - Undefined: SEARCH is unreachable, line=000 in TRACK holds the previous mode, and fault stays 0.

Structure
REQ-020 Package drive_pkg SHALL hold:
 - the state enum;
 - mode codes MODE_STOP=0, FWD=1, LEFT=2, RIGHT=3, SHARP_LEFT=4, SHARP_RIGHT=5, BACK=6;
 - the four direction constants.
REQ-021 The line-to-mode decode SHALL be a combinational sub-module line_decode (line, prev_mode -> mode, turn_side).

Verification
REQ-022 The bench SHALL use BRAKE_CYC=4, BACK_CYC=8, CLEAR_CYC=3, SEARCH_CYC=10 and cover:
 - Reset then start; line=010 -> next cycle TRACK; the cycle after: mode=1, left=right=01.
 - line 110 then 100 then 101 -> mode 2, 4, 4.
 - stop pulse in TRACK -> 4 cycles of 11, then 8 cycles of 10 / mode 6; stop re-pulsed during BACKUP has no effect; WAIT_CLEAR stop toggling 1,0,0,1,0,0,0 -> TRACK only after the last three lows.
 - SEARCH_EN defined, last_dir=right, line=000 -> left=01, right=10; line=001 at cycle 5 -> TRACK mode=5; line held 000 for 10 cycles -> IDLE with fault=1.
 - SEARCH_EN undefined, line=000 -> previous mode held, state stays TRACK.
 - rst_n low during BACKUP cycle 3 -> next cycle IDLE, left=right=11, mode=0.
